down_timer_ctrl: RTL and testbench

- Programmable 8-bit countdown timer controller.
- Owns the count register that drives the constant-decrement subtractor stage and takes its difference result back each tick.
- Adds a prescaler, start/pause/stop control, optional auto-reload and a terminal-count pulse.
- Sits directly upstream and downstream of the decrement datapath. Consumers see only count, busy and tc_pulse.

---
 rtl/down_timer_pkg.sv | 6 +
 rtl/down_timer_dec.sv | 10 +
 rtl/down_timer_ctrl.sv | 113 +++++++++++
 tb/tb_down_timer_ctrl.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/down_timer_pkg.sv
// down_timer_pkg: shared state encoding and default widths for the countdown timer
package down_timer_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  localparam int WIDTH_DEF = 8;
  localparam int PRE_W_DEF = 4;
endpackage

// File: rtl/down_timer_dec.sv
// down_timer_dec: combinational decrement-by-one with borrow out
module down_timer_dec #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y,
  output logic             borrow
);
  assign {borrow, y} = {1'b0, a} - {{WIDTH{1'b0}}, 1'b1};
endmodule

// File: rtl/down_timer_ctrl.sv
// down_timer_ctrl: prescaled 8-bit countdown timer with start/pause/stop, auto-reload and terminal-count pulse
module down_timer_ctrl
  import down_timer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int PRE_W = PRE_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  input  logic             auto_reload,
  input  logic [PRE_W-1:0] prescale,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc_pulse,
  output logic             start_err
);
  state_t           state;
  logic [WIDTH-1:0] reload_reg;
  logic [WIDTH-1:0] dec_val;
  logic [PRE_W-1:0] pre_cnt;
  logic             borrow;
  logic             tick;
  logic             last;

  down_timer_dec #(.WIDTH(WIDTH)) u_dec (
    .a(count),
    .y(dec_val),
    .borrow(borrow)
  );

  assign tick = pre_cnt == prescale;
  // count==1 exactly when the decrement lands on zero without borrowing
  assign last = (dec_val == '0) && !borrow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      reload_reg <= '0;
      pre_cnt    <= '0;
      busy       <= 1'b0;
      tc_pulse   <= 1'b0;
      start_err  <= 1'b0;
    end else begin
      tc_pulse  <= 1'b0;
      start_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!stop) begin
            if (load) begin
              reload_reg <= load_val;
              count      <= load_val;
            end else if (!pause && start) begin
              if (count != '0) begin
                state   <= RUN;
                busy    <= 1'b1;
                pre_cnt <= '0;
              end else begin
                start_err <= 1'b1;
              end
            end
          end
        end
        RUN: begin
          if (stop) begin
            state   <= IDLE;
            busy    <= 1'b0;
            pre_cnt <= '0;
          end else if (!load && pause) begin
            state <= PAUSE;
          end else begin
            if (load) reload_reg <= load_val;
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            if (tick) begin
              if (last) begin
                tc_pulse <= 1'b1;
                if (auto_reload && reload_reg != '0) begin
                  count <= reload_reg;
                end else begin
                  count <= '0;
                  state <= IDLE;
                  busy  <= 1'b0;
                end
              end else if (!borrow) begin
                count <= dec_val;
              end
            end
          end
        end
        PAUSE: begin
          if (stop) begin
            state   <= IDLE;
            busy    <= 1'b0;
            pre_cnt <= '0;
          end else if (load) begin
            reload_reg <= load_val;
          end else if (start) begin
            state <= RUN;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_down_timer_ctrl.sv
// tb_down_timer_ctrl: table-driven and scoreboarded checks of the countdown timer
module tb_down_timer_ctrl;
  typedef struct {
    logic       ld;
    logic [7:0] lv;
    logic       st, pa, sp, ar;
    logic [3:0] ps;
    logic [7:0] c;
    logic       b, tc, er;
  } vec_t;

  typedef struct packed {
    logic [7:0] c;
    logic       b, tc, er;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0, start = 1'b0, pause = 1'b0, stop = 1'b0, auto_reload = 1'b0;
  logic [7:0] load_val = '0;
  logic [3:0] prescale = '0;
  logic [7:0] count;
  logic       busy, tc_pulse, start_err;

  int   n_vec = 0;
  int   n_bad = 0;
  exp_t sb[$];
  vec_t tv[19];

  down_timer_ctrl dut (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val), .start(start),
    .pause(pause), .stop(stop), .auto_reload(auto_reload), .prescale(prescale),
    .count(count), .busy(busy), .tc_pulse(tc_pulse), .start_err(start_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input exp_t e);
    exp_t a;
    a = '{count, busy, tc_pulse, start_err};
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got count=%0d busy=%b tc=%b err=%b, want count=%0d busy=%b tc=%b err=%b",
               nm, a.c, a.b, a.tc, a.er, e.c, e.b, e.tc, e.er);
    end
  endtask

  task automatic cyc(input string nm, input vec_t v);
    @(negedge clk);
    load = v.ld; load_val = v.lv; start = v.st; pause = v.pa;
    stop = v.sp; auto_reload = v.ar; prescale = v.ps;
    sb.push_back('{v.c, v.b, v.tc, v.er});
    @(posedge clk);
    #1;
    check(nm, sb.pop_front());
  endtask

  function automatic vec_t mk(input logic ld, input logic [7:0] lv, input logic st, input logic pa,
                              input logic sp, input logic ar, input logic [3:0] ps,
                              input logic [7:0] c, input logic b, input logic tc, input logic er);
    mk = '{ld, lv, st, pa, sp, ar, ps, c, b, tc, er};
  endfunction

  initial begin
    // basic count of 5 at prescale 0
    tv[0]  = mk(1, 5, 0, 0, 0, 0, 0,  5, 0, 0, 0);
    tv[1]  = mk(0, 0, 1, 0, 0, 0, 0,  5, 1, 0, 0);
    tv[2]  = mk(0, 0, 0, 0, 0, 0, 0,  4, 1, 0, 0);
    tv[3]  = mk(0, 0, 0, 0, 0, 0, 0,  3, 1, 0, 0);
    tv[4]  = mk(0, 0, 0, 0, 0, 0, 0,  2, 1, 0, 0);
    tv[5]  = mk(0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0);
    tv[6]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0);
    tv[7]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    // start with count zero is rejected
    tv[8]  = mk(0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 1);
    tv[9]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    // load beats start in the same cycle
    tv[10] = mk(1, 3, 1, 0, 0, 0, 0,  3, 0, 0, 0);
    tv[11] = mk(0, 0, 0, 0, 0, 0, 0,  3, 0, 0, 0);
    // auto-reload of 2
    tv[12] = mk(1, 2, 0, 0, 0, 1, 0,  2, 0, 0, 0);
    tv[13] = mk(0, 0, 1, 0, 0, 1, 0,  2, 1, 0, 0);
    tv[14] = mk(0, 0, 0, 0, 0, 1, 0,  1, 1, 0, 0);
    tv[15] = mk(0, 0, 0, 0, 0, 1, 0,  2, 1, 1, 0);
    tv[16] = mk(0, 0, 0, 0, 0, 1, 0,  1, 1, 0, 0);
    tv[17] = mk(0, 0, 0, 0, 0, 1, 0,  2, 1, 1, 0);
    tv[18] = mk(0, 0, 0, 0, 1, 1, 0,  2, 0, 0, 0);

    #2;
    check("reset_async", '{8'd0, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    @(negedge clk);
    check("reset_held", '{8'd0, 1'b0, 1'b0, 1'b0});
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) cyc($sformatf("tv%0d", i), tv[i]);

    // prescale 2: decrement every 3 edges, terminal pulse on the 9th edge after start
    cyc("pre_load", mk(1, 3, 0, 0, 0, 0, 2, 3, 0, 0, 0));
    cyc("pre_start", mk(0, 0, 1, 0, 0, 0, 2, 3, 1, 0, 0));
    for (int k = 1; k <= 10; k++)
      cyc($sformatf("pre_k%0d", k),
          mk(0, 0, 0, 0, 0, 0, 2, (k < 9) ? 8'(3 - k / 3) : 8'd0, k < 9, k == 9, 0));

    // reload value updated mid-run is used at the next terminal tick
    cyc("lr_load", mk(1, 4, 0, 0, 0, 1, 0, 4, 0, 0, 0));
    cyc("lr_start", mk(0, 0, 1, 0, 0, 1, 0, 4, 1, 0, 0));
    cyc("lr_3", mk(0, 0, 0, 0, 0, 1, 0, 3, 1, 0, 0));
    cyc("lr_2", mk(0, 0, 0, 0, 0, 1, 0, 2, 1, 0, 0));
    cyc("lr_ld7", mk(1, 7, 0, 0, 0, 1, 0, 1, 1, 0, 0));
    cyc("lr_rel", mk(0, 0, 0, 0, 0, 1, 0, 7, 1, 1, 0));
    cyc("lr_6", mk(0, 0, 0, 0, 0, 1, 0, 6, 1, 0, 0));
    cyc("lr_stop", mk(0, 0, 0, 0, 1, 1, 0, 6, 0, 0, 0));

    // pause holds, start resumes, stop on the terminal tick suppresses the pulse
    cyc("pz_load", mk(1, 5, 0, 0, 0, 0, 0, 5, 0, 0, 0));
    cyc("pz_start", mk(0, 0, 1, 0, 0, 0, 0, 5, 1, 0, 0));
    cyc("pz_4", mk(0, 0, 0, 0, 0, 0, 0, 4, 1, 0, 0));
    cyc("pz_3", mk(0, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0));
    cyc("pz_pause", mk(0, 0, 0, 1, 0, 0, 0, 3, 1, 0, 0));
    for (int i = 0; i < 10; i++)
      cyc($sformatf("pz_hold%0d", i), mk(0, 0, 0, i % 3 == 0, 0, 0, 0, 3, 1, 0, 0));
    cyc("pz_resume", mk(0, 0, 1, 0, 0, 0, 0, 3, 1, 0, 0));
    cyc("pz_2", mk(0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
    cyc("pz_1", mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    cyc("pz_stop_tc", mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0));
    cyc("pz_after", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));

    // asynchronous reset mid-run
    cyc("rs_load", mk(1, 9, 0, 0, 0, 0, 0, 9, 0, 0, 0));
    cyc("rs_start", mk(0, 0, 1, 0, 0, 0, 0, 9, 1, 0, 0));
    cyc("rs_8", mk(0, 0, 0, 0, 0, 0, 0, 8, 1, 0, 0));
    #2;
    rst_n = 1'b0;
    #1;
    check("rs_async", '{8'd0, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    cyc("rs_after", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
